cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Execution controller that sequences the RV32I core from the 100 MHz board clock. It turns a raw step push-button and a run switch into a one-cycle-per-instruction enable, `cpu_en`, which replaces the free-running `clk_on` execution clock. It supports single-step, free-run at a divided rate, and a halted state entered from a CPU halt request or a PC breakpoint. It also keeps an executed-instruction counter for display and debug.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable synchronized samples needed to accept a new button level. Must be ≥ 1.
- `RUN_DIV`, default 10: clk cycles per instruction in RUN. Must be ≥ 2.
- `CNT_W`, default 32: width of `step_cnt`.

- `clk`  in  1  board clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `step_btn`  in  1  raw step push-button, asynchronous to `clk`, bouncy.
- `run_sw`  in  1  run switch level, asynchronous to `clk`.
- `halt`  in  1  synchronous halt request from the core (e.g. ebreak decode); a level.
- `bp_en`  in  1  breakpoint enable, synchronous.
- `bp_addr`  in  32  breakpoint PC.
- `pc`  in  32  PC of the next instruction the core will execute.
- `cpu_en`  out  1  registered; one-clk-wide pulse, and each pulse executes one instruction.
- `state`  out  2  registered; IDLE=0, RUN=1, HALTED=2. Encoding 3 is never produced.
- `step_cnt`  out  CNT_W  registered count of `cpu_en` pulses.

## Operation
- **Input synchronization**
  - `step_btn` and `run_sw` each pass through a 2-flop synchronizer.
  - `run_sw` is not debounced.
- **Step debounce**
  - The debounced level `db` (reset 0) has a counter.
  - The counter clears on any cycle where the synchronized level equals `db`.
  - Otherwise it increments. When it has counted `DEBOUNCE_CYCLES` consecutive differing cycles, `db` takes the new level and the counter clears.
  - A registered rising edge of `db` produces a one-cycle internal `step_req`.
- **FSM, state IDLE**
  - `step_req` → pulse `cpu_en`; remain IDLE.
  - Synchronized `run_sw`=1 → RUN, with the divider cleared.
- **FSM, state RUN**
  - The divider counts 0..RUN_DIV-1 and wraps.
  - The fire point is the divider at RUN_DIV-1.
  - At the fire point `cpu_en` pulses, unless a halt or breakpoint applies (below).
  - `step_req` is ignored.
- **FSM, priority in RUN (highest first)**
  1. Synchronized `run_sw`=0 → IDLE, no pulse.
  2. `halt`=1 on any cycle → HALTED, no pulse that cycle.
  3. At the fire point, `bp_en`=1 and `pc==bp_addr` → HALTED, no pulse.
  4. Otherwise pulse at the fire point.
- **FSM, state HALTED**
  - `step_req` → pulse `cpu_en`. The breakpoint is ignored, so a step always executes. Remain HALTED.
  - Synchronized `run_sw`=0 → IDLE.
  - `halt` is ignored.
  - Re-entering RUN requires `run_sw` to go 0 → 1.
- **Counter**
  - `step_cnt` increments on every cycle in which `cpu_en` is 1.
  - It wraps modulo 2^CNT_W with no saturation.
- **Other FSM rules**
  - Leaving RUN clears the divider.
  - `step_req` arriving in the same cycle as a state transition is dropped.

## Timing
- **Reset**
  - All outputs go to 0 immediately, with no clock edge needed.
  - Synchronizers, `db`, the edge register, the debounce counter, the divider and the FSM also reset to 0.
  - A button held through reset yields exactly one step after release, following the full debounce latency.
- **Step latency**
  - Edge 1 is the first `clk` rise that samples `step_btn`=1, with the input stable afterwards.
  - `db` rises at edge DEBOUNCE_CYCLES+2.
  - `cpu_en` is high for exactly one cycle, after edge DEBOUNCE_CYCLES+3.
- **Glitch rejection**
  - A synchronized pulse shorter than DEBOUNCE_CYCLES cycles produces no step.
  - Release is debounced identically.
- **Run entry**
  - `state` becomes RUN after edge 3 counted from the first edge sampling `run_sw`=1.
  - The first pulse comes RUN_DIV cycles later; after that, pulses are exactly RUN_DIV cycles apart.
- **Halt and breakpoint**
  - `halt` or a breakpoint hit is acted on at the same edge: `state` = HALTED after that edge, and `cpu_en` stays 0.
- **Run exit**
  - Falling `run_sw` reaches IDLE 3 edges after the first edge sampling 0.
  - At most one pulse can occur inside that window, and only if the fire point falls within it.
- **Counter latency**
  - `step_cnt` updates at the edge that ends the `cpu_en` cycle, so it is visible one cycle after the pulse.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, RUN_DIV=10, CNT_W=32.
1. **Reset**: assert `rst` between clk edges in any state → `cpu_en`=0, `state`=0 and `step_cnt`=0 immediately. After release with inputs low: no pulses for 50 cycles.
2. **Debounce**:
   - Hold `step_btn`=1 for 20 cycles → exactly one `cpu_en` pulse, after edge 7; `step_cnt`=1.
   - A 3-cycle `step_btn` glitch → no pulse.
   - Bouncing high/low every 2 cycles for 12 cycles, then steady high → one pulse.
3. **Run**: `run_sw`=1 for 103 cycles → `state`=1 after edge 3. Pulses are exactly 10 cycles apart, 10 pulses in total, and `step_cnt`=10.
4. **Breakpoint**: bp_en=1, bp_addr=0x0000000C; a bench model starts `pc` at 0 and adds 4 per pulse; run.
   - Expect 3 pulses (pc 0, 4, 8), then `state`=2 with `step_cnt`=3.
   - A step press → one pulse, `step_cnt`=4, `state` remains 2.
5. **Halt in RUN**:
   - `halt`=1 on the fire-point cycle → no pulse, `state`=2.
   - Then `run_sw`=0 → `state`=0 within 3 cycles.
   - Then `run_sw`=1 → RUN, and pulses resume.
6. **Counter wrap and reset in RUN**:
   - Force `step_cnt` to 0xFFFFFFFF (hierarchical deposit), run 1 pulse → `step_cnt`=0.
   - Assert `rst` mid-RUN, 5 cycles after a pulse → all outputs 0 at once.
   - After release, with `run_sw` still 1: first pulse comes 3+10 cycles later.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the RV32I core: turns a bouncy step button and a run
// switch into a one-clock-per-instruction enable, with halt/breakpoint handling.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 10,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             halt,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  logic             r_btn_s1, r_btn_s2;
  logic             r_run_s1, r_run_s2;
  logic             r_db, r_db_d;
  logic [DB_W-1:0]  r_db_cnt;
  logic [DIV_W-1:0] r_div;
  state_t           r_state;
  logic             r_cpu_en;
  logic [CNT_W-1:0] r_step_cnt;

  logic             w_step_req;
  logic             w_fire;
  logic             w_bp_hit;
  state_t           w_next_state;
  logic             w_next_en;
  logic [DIV_W-1:0] w_div_next;

  // Synchronizers and step debounce; db only moves after DEBOUNCE_CYCLES
  // consecutive samples that disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
      r_db     <= 1'b0;
      r_db_d   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_btn_s1 <= step_btn;
      r_btn_s2 <= r_btn_s1;
      r_run_s1 <= run_sw;
      r_run_s2 <= r_run_s1;
      r_db_d   <= r_db;
      if (r_btn_s2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db     <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_step_req = r_db & ~r_db_d;
  assign w_fire     = (r_div == DIV_LAST);
  assign w_bp_hit   = bp_en && (pc == bp_addr);

  always_comb begin
    w_next_state = r_state;
    w_next_en    = 1'b0;
    w_div_next   = '0;
    case (r_state)
      S_IDLE: begin
        if (r_run_s2) begin
          w_next_state = S_RUN;
        end else if (w_step_req) begin
          w_next_en = 1'b1;
        end
      end
      S_RUN: begin
        if (!r_run_s2) begin
          w_next_state = S_IDLE;
        end else if (halt) begin
          w_next_state = S_HALTED;
        end else if (w_fire && w_bp_hit) begin
          w_next_state = S_HALTED;
        end else begin
          w_next_en  = w_fire;
          w_div_next = w_fire ? '0 : r_div + DIV_W'(1);
        end
      end
      S_HALTED: begin
        // A step always executes here, even sitting on the breakpoint PC.
        if (!r_run_s2) begin
          w_next_state = S_IDLE;
        end else if (w_step_req) begin
          w_next_en = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_cpu_en   <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_div    <= w_div_next;
      r_cpu_en <= w_next_en;
      if (r_cpu_en) begin
        r_step_cnt <= r_step_cnt + CNT_W'(1);
      end
    end
  end

  assign cpu_en   = r_cpu_en;
  assign state    = r_state;
  assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: expected pulses are queued by the stimulus thread and
// matched by a monitor whenever cpu_en is seen high.
module tb_cpu_run_ctrl;

  localparam int DEB  = 4;
  localparam int RDIV = 10;
  localparam int CW   = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          step_btn = 1'b0;
  logic          run_sw   = 1'b0;
  logic          halt     = 1'b0;
  logic          bp_en    = 1'b0;
  logic [31:0]   bp_addr  = 32'h0;
  logic [31:0]   pc;
  logic          cpu_en;
  logic [1:0]    state;
  logic [CW-1:0] step_cnt;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;
  int pc_cnt = 0;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_DIV        (RDIV),
    .CNT_W          (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .step_btn(step_btn),
    .run_sw  (run_sw),
    .halt    (halt),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .pc      (pc),
    .cpu_en  (cpu_en),
    .state   (state),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: each executed instruction advances the PC by 4.
  assign pc = {pc_cnt[29:0], 2'b00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [1:0] st, input logic [31:0] cnt);
    exp_t e;
    e.cyc = c;
    e.st  = st;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pc_cnt = 0;
    end else if (cpu_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_state", {30'b0, state}, {30'b0, e.st});
        chk("pulse_cnt", step_cnt, e.cnt);
      end
      pc_cnt = pc_cnt + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // Reset from power-up, then idle with inputs low.
    #2 rst = 1'b1;
    #1;
    chk("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
    chk("rst_state", {30'b0, state}, 32'd0);
    chk("rst_cnt", step_cnt, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c = cyc;
    wait_to(c + 50);
    chk("idle_state", {30'b0, state}, 32'd0);
    chk("idle_cnt", step_cnt, 32'd0);

    // Clean press: pulse after edge DEB+3.
    c = cyc;
    step_btn = 1'b1;
    expect_pulse(c + 7, ST_IDLE, 32'd0);
    wait_to(c + 20);
    step_btn = 1'b0;
    wait_to(c + 40);
    chk("press_cnt", step_cnt, 32'd1);
    chk("press_q_empty", q.size(), 32'd0);

    // 3-cycle glitch is rejected.
    c = cyc;
    step_btn = 1'b1;
    wait_to(c + 3);
    step_btn = 1'b0;
    wait_to(c + 25);
    chk("glitch_cnt", step_cnt, 32'd1);

    // Bounce every 2 cycles for 12 cycles, then steady high.
    c = cyc;
    expect_pulse(c + 19, ST_IDLE, 32'd1);
    for (int i = 0; i < 12; i++) begin
      step_btn = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    step_btn = 1'b1;
    wait_to(c + 40);
    step_btn = 1'b0;
    wait_to(c + 60);
    chk("bounce_cnt", step_cnt, 32'd2);
    chk("bounce_q_empty", q.size(), 32'd0);

    // Free run for 103 cycles: 10 pulses, 10 apart.
    do_reset();
    c = cyc;
    run_sw = 1'b1;
    for (int k = 0; k < 10; k++) expect_pulse(c + 13 + 10 * k, ST_RUN, 32'(k));
    wait_to(c + 2);
    chk("run_entry_early", {30'b0, state}, 32'd0);
    wait_to(c + 3);
    chk("run_entry", {30'b0, state}, 32'd1);
    wait_to(c + 103);
    run_sw = 1'b0;
    wait_to(c + 105);
    chk("run_exit_early", {30'b0, state}, 32'd1);
    wait_to(c + 106);
    chk("run_exit", {30'b0, state}, 32'd0);
    wait_to(c + 130);
    chk("run_cnt", step_cnt, 32'd10);
    chk("run_q_empty", q.size(), 32'd0);

    // Breakpoint at 0xC: pulses at pc 0, 4, 8 then halt.
    bp_addr = 32'h0000_000C;
    bp_en   = 1'b1;
    do_reset();
    c = cyc;
    run_sw = 1'b1;
    expect_pulse(c + 13, ST_RUN, 32'd0);
    expect_pulse(c + 23, ST_RUN, 32'd1);
    expect_pulse(c + 33, ST_RUN, 32'd2);
    wait_to(c + 42);
    chk("bp_before", {30'b0, state}, 32'd1);
    wait_to(c + 43);
    chk("bp_halted", {30'b0, state}, 32'd2);
    chk("bp_cnt", step_cnt, 32'd3);
    wait_to(c + 50);
    chk("bp_stays", {30'b0, state}, 32'd2);
    c = cyc;
    step_btn = 1'b1;
    expect_pulse(c + 7, ST_HALT, 32'd3);
    wait_to(c + 20);
    step_btn = 1'b0;
    wait_to(c + 40);
    chk("bp_step_cnt", step_cnt, 32'd4);
    chk("bp_step_state", {30'b0, state}, 32'd2);
    chk("bp_q_empty", q.size(), 32'd0);
    c = cyc;
    run_sw = 1'b0;
    bp_en  = 1'b0;
    wait_to(c + 3);
    chk("bp_to_idle", {30'b0, state}, 32'd0);

    // Halt on the fire-point cycle, leave via run_sw=0, re-enter RUN.
    do_reset();
    c = cyc;
    run_sw = 1'b1;
    expect_pulse(c + 13, ST_RUN, 32'd0);
    expect_pulse(c + 23, ST_RUN, 32'd1);
    wait_to(c + 32);
    halt = 1'b1;
    wait_to(c + 33);
    halt = 1'b0;
    chk("halt_state", {30'b0, state}, 32'd2);
    chk("halt_no_pulse", {31'b0, cpu_en}, 32'd0);
    wait_to(c + 40);
    chk("halt_cnt", step_cnt, 32'd2);
    c = cyc;
    run_sw = 1'b0;
    wait_to(c + 2);
    chk("halt_exit_early", {30'b0, state}, 32'd2);
    wait_to(c + 3);
    chk("halt_exit", {30'b0, state}, 32'd0);
    c = cyc;
    run_sw = 1'b1;
    expect_pulse(c + 13, ST_RUN, 32'd2);
    wait_to(c + 3);
    chk("rerun_state", {30'b0, state}, 32'd1);
    wait_to(c + 14);
    chk("rerun_cnt", step_cnt, 32'd3);
    run_sw = 1'b0;
    wait_to(c + 20);
    chk("rerun_q_empty", q.size(), 32'd0);

    // Counter wrap, then asynchronous reset mid-RUN.
    do_reset();
    c = cyc;
    run_sw = 1'b1;
    expect_pulse(c + 13, ST_RUN, 32'd0);
    wait_to(c + 15);
    dut.r_step_cnt = 32'hFFFF_FFFF;
    expect_pulse(c + 23, ST_RUN, 32'hFFFF_FFFF);
    expect_pulse(c + 33, ST_RUN, 32'd0);
    wait_to(c + 24);
    chk("wrap_cnt", step_cnt, 32'd0);
    wait_to(c + 38);
    chk("pre_rst_cnt", step_cnt, 32'd1);
    chk("pre_rst_state", {30'b0, state}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_cpu_en", {31'b0, cpu_en}, 32'd0);
    chk("midrun_rst_state", {30'b0, state}, 32'd0);
    chk("midrun_rst_cnt", step_cnt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    expect_pulse(c + 13, ST_RUN, 32'd0);
    wait_to(c + 3);
    chk("post_rst_run", {30'b0, state}, 32'd1);
    wait_to(c + 14);
    chk("post_rst_cnt", step_cnt, 32'd1);
    run_sw = 1'b0;
    wait_to(c + 20);
    chk("post_rst_idle", {30'b0, state}, 32'd0);
    chk("final_q_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
